// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder.
// Matrices are packed row-major, so element (i,j) is at index 3*i+j.
package systolic_pkg;
  localparam int DW_DEF     = 8;
  localparam int CW_DEF     = 17;
  localparam int N          = 3;
  localparam int FEED_BEATS = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_e;

  function automatic int idx(input int i, input int j);
    return N * i + j;
  endfunction

  function automatic int lsb(input int i, input int j, input int w);
    return idx(i, j) * w;
  endfunction
endpackage

// File: rtl/systolic_feeder_skew_sel.sv
// Combinational diagonal-skew selector: for beat t, lane i carries A[i][t-i]
// and lane j carries B[t-j][j], or zero when the index falls outside the matrix.
module skew_sel
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]      t_i,
  input  logic [9*DW-1:0] mat_a_i,
  input  logic [9*DW-1:0] mat_b_i,
  output logic [3*DW-1:0] a_o,
  output logic [3*DW-1:0] b_o
);

  int k;

  always_comb begin
    a_o = '0;
    b_o = '0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(t_i) - i;
      if (k >= 0 && k < N) begin
        a_o[i*DW +: DW] = mat_a_i[lsb(i, k, DW) +: DW];
        b_o[i*DW +: DW] = mat_b_i[lsb(k, i, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Host-side sequencer for the 3x3 systolic multiplier: accepts A/B, clears the
// array, streams the skewed operands, waits for the drain and returns C.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int CW           = CW_DEF,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] mat_a,
  input  logic [9*DW-1:0] mat_b,
  output logic            arr_reset,
  output logic [DW-1:0]   a1,
  output logic [DW-1:0]   a2,
  output logic [DW-1:0]   a3,
  output logic [DW-1:0]   b1,
  output logic [DW-1:0]   b2,
  output logic [DW-1:0]   b3,
  input  logic [CW-1:0]   c1,
  input  logic [CW-1:0]   c2,
  input  logic [CW-1:0]   c3,
  input  logic [CW-1:0]   c4,
  input  logic [CW-1:0]   c5,
  input  logic [CW-1:0]   c6,
  input  logic [CW-1:0]   c7,
  input  logic [CW-1:0]   c8,
  input  logic [CW-1:0]   c9,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [9*CW-1:0] res
);

  state_e            state_q, state_d;
  logic [2:0]        t_q, t_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [9*DW-1:0]   mat_a_q, mat_a_d;
  logic [9*DW-1:0]   mat_b_q, mat_b_d;
  logic              in_ready_q, in_ready_d;
  logic              arr_reset_q, arr_reset_d;
  logic [3*DW-1:0]   a_q, a_d;
  logic [3*DW-1:0]   b_q, b_d;
  logic              res_valid_q, res_valid_d;
  logic [9*CW-1:0]   res_q, res_d;
  logic [2:0]        t_sel;
  logic [3*DW-1:0]   skew_a, skew_b;

  // Lanes are registered, so the selector always looks one beat ahead.
  assign t_sel = (state_q == CLEAR) ? 3'd0 : t_q + 3'd1;

  skew_sel #(.DW(DW)) u_skew (
    .t_i     (t_sel),
    .mat_a_i (mat_a_q),
    .mat_b_i (mat_b_q),
    .a_o     (skew_a),
    .b_o     (skew_b)
  );

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    in_ready_d  = in_ready_q;
    arr_reset_d = arr_reset_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mat_a_d     = mat_a;
          mat_b_d     = mat_b;
          in_ready_d  = 1'b0;
          arr_reset_d = 1'b1;
          a_d         = '0;
          b_d         = '0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        arr_reset_d = 1'b0;
        t_d         = 3'd0;
        a_d         = skew_a;
        b_d         = skew_b;
        state_d     = FEED;
      end
      FEED: begin
        if (t_q == 3'(FEED_BEATS - 1)) begin
          a_d     = '0;
          b_d     = '0;
          cnt_d   = 4'd0;
          state_d = DRAIN;
        end else begin
          t_d = t_q + 3'd1;
          a_d = skew_a;
          b_d = skew_b;
        end
      end
      DRAIN: begin
        // DRAIN_CYCLES idle cycles after the last beat, then one capture cycle.
        if (cnt_q == 4'(DRAIN_CYCLES)) begin
          res_d       = {c9, c8, c7, c6, c5, c4, c3, c2, c1};
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      in_ready_q  <= 1'b1;
      arr_reset_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      in_ready_q  <= in_ready_d;
      arr_reset_q <= arr_reset_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign arr_reset = arr_reset_q;
  assign a1        = a_q[0*DW +: DW];
  assign a2        = a_q[1*DW +: DW];
  assign a3        = a_q[2*DW +: DW];
  assign b1        = b_q[0*DW +: DW];
  assign b2        = b_q[1*DW +: DW];
  assign b3        = b_q[2*DW +: DW];
  assign res_valid = res_valid_q;
  assign res       = res_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: two instances (drain 4 and drain 1), each with a
// behavioural systolic array whose result latency matches its drain setting.
module tb_systolic_feeder;
  localparam int TDW = 8;
  localparam int TCW = 18;
  localparam int NI  = 2;

  typedef logic [9*TDW-1:0] mat_t;
  typedef logic [9*TCW-1:0] res_t;
  typedef int m9_t [9];
  typedef struct {
    mat_t  a;
    mat_t  b;
    res_t  exp;
    string nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic           inv  [NI];
  logic           inr  [NI];
  mat_t           ma   [NI];
  mat_t           mb   [NI];
  logic           arr_r[NI];
  logic [TDW-1:0] av   [NI][3];
  logic [TDW-1:0] bv   [NI][3];
  logic           rv   [NI];
  logic           rr   [NI];
  res_t           resv [NI];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DC  = (g == 0) ? 4 : 1;
    localparam int LAG = DC + 1;
    logic [TCW-1:0] cl [9];
    longint ah [3][64];
    longint bh [3][64];
    longint ring [32][9];
    longint s;
    int m = 0;
    int cyc = 0;

    systolic_feeder #(.DW(TDW), .CW(TCW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .reset(reset_n),
      .in_valid(inv[g]), .in_ready(inr[g]), .mat_a(ma[g]), .mat_b(mb[g]),
      .arr_reset(arr_r[g]),
      .a1(av[g][0]), .a2(av[g][1]), .a3(av[g][2]),
      .b1(bv[g][0]), .b2(bv[g][1]), .b3(bv[g][2]),
      .c1(cl[0]), .c2(cl[1]), .c3(cl[2]), .c4(cl[3]), .c5(cl[4]),
      .c6(cl[5]), .c7(cl[6]), .c8(cl[7]), .c9(cl[8]),
      .res_valid(rv[g]), .res_ready(rr[g]), .res(resv[g])
    );

    // Array model: PE(i,j) multiplies the lane-i and lane-j samples that carry
    // the same inner index k; the sums appear on c* LAG cycles later.
    always @(negedge clk) begin
      if (arr_r[g]) m = 0;
      else if (m < 64) begin
        for (int i = 0; i < 3; i++) begin
          ah[i][m] = longint'(av[g][i]);
          bh[i][m] = longint'(bv[g][i]);
        end
        m++;
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          s = 0;
          for (int k = 0; k + i < m && k + j < m; k++) s += ah[i][k+i] * bh[j][k+j];
          ring[cyc % 32][3*i+j] = s;
        end
      for (int e = 0; e < 9; e++)
        cl[e] = (cyc >= LAG) ? TCW'(ring[(cyc - LAG) % 32][e]) : '0;
      cyc++;
    end
  end

  function automatic mat_t pk(input m9_t v);
    mat_t r;
    for (int e = 0; e < 9; e++) r[e*TDW +: TDW] = TDW'(v[e]);
    return r;
  endfunction

  function automatic res_t pr(input m9_t v);
    res_t r;
    for (int e = 0; e < 9; e++) r[e*TCW +: TCW] = TCW'(v[e]);
    return r;
  endfunction

  function automatic res_t matmul(input mat_t a, input mat_t b);
    res_t r;
    int sum;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        sum = 0;
        for (int k = 0; k < 3; k++)
          sum += int'(a[(3*i+k)*TDW +: TDW]) * int'(b[(3*k+j)*TDW +: TDW]);
        r[(3*i+j)*TCW +: TCW] = TCW'(sum);
      end
    return r;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t r;
    for (int e = 0; e < 9; e++) r[e*TDW +: TDW] = TDW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [3*TDW-1:0] lanes_a(input int g);
    return {av[g][2], av[g][1], av[g][0]};
  endfunction

  function automatic logic [3*TDW-1:0] lanes_b(input int g);
    return {bv[g][2], bv[g][1], bv[g][0]};
  endfunction

  task automatic start_job(input int g, input mat_t a, input mat_t b);
    bit ok;
    ok = 0;
    ma[g] = a;
    mb[g] = b;
    inv[g] = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (inr[g]) ok = 1;
      tick();
    end
    inv[g] = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_res(input int g, output int lat, output int arr_hi);
    lat = 0;
    arr_hi = 0;
    while (!rv[g] && lat < 60) begin
      if (arr_r[g]) arr_hi++;
      tick();
      lat++;
    end
  endtask

  task automatic run_job(input int g, input mat_t a, input mat_t b, input res_t exp, input string nm);
    int lat, arr_hi;
    start_job(g, a, b);
    wait_res(g, lat, arr_hi);
    chk({nm, "_latency"}, lat, 7 + ((g == 0) ? 4 : 1));
    chk({nm, "_arr_reset_cycles"}, arr_hi, 1);
    chk({nm, "_res"}, resv[g], exp);
    tick();
    chk({nm, "_valid_drop"}, rv[g], 0);
    chk({nm, "_ready_back"}, inr[g], 1);
  endtask

  initial begin
    vec_t tbl [5];
    int fa [5][3];
    int fb [5][3];
    mat_t a_d, b_d, id, f255, ra, rb;
    res_t saved;
    int lat, arr_hi;

    for (int g = 0; g < NI; g++) begin
      inv[g] = 1'b0;
      rr[g] = 1'b1;
      ma[g] = '0;
      mb[g] = '0;
    end

    a_d  = pk('{3, 12, 4, 5, 6, 8, 1, 0, 2});
    b_d  = pk('{7, 3, 8, 11, 9, 5, 6, 8, 4});
    id   = pk('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    f255 = pk('{255, 255, 255, 255, 255, 255, 255, 255, 255});
    fa = '{'{3, 0, 0}, '{12, 5, 0}, '{4, 6, 1}, '{0, 8, 0}, '{0, 0, 2}};
    fb = '{'{7, 0, 0}, '{11, 3, 0}, '{6, 9, 8}, '{0, 8, 5}, '{0, 0, 4}};

    #1 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", inr[0], 1);
    chk("rst_res_valid", rv[0], 0);
    chk("rst_arr_reset", arr_r[0], 0);
    chk("rst_lanes", {lanes_a(0), lanes_b(0)}, 0);
    chk("rst_res", resv[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Directed product, checking every feed beat.
    start_job(0, a_d, b_d);
    chk("clear_arr_reset", arr_r[0], 1);
    chk("clear_lanes", {lanes_a(0), lanes_b(0)}, 0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("feed_a_t%0d", t), lanes_a(0),
          {TDW'(fa[t][2]), TDW'(fa[t][1]), TDW'(fa[t][0])});
      chk($sformatf("feed_b_t%0d", t), lanes_b(0),
          {TDW'(fb[t][2]), TDW'(fb[t][1]), TDW'(fb[t][0])});
      chk($sformatf("feed_arr_t%0d", t), arr_r[0], 0);
    end
    tick();
    chk("drain_lanes", {lanes_a(0), lanes_b(0)}, 0);
    lat = 6;
    while (!rv[0] && lat < 60) begin
      tick();
      lat++;
    end
    chk("directed_latency", lat, 11);
    chk("directed_res", resv[0], pr('{177, 149, 100, 149, 133, 102, 19, 19, 16}));
    tick();
    chk("directed_valid_one_cycle", rv[0], 0);
    chk("directed_idle", inr[0], 1);

    // Table of back-to-back jobs.
    ra = rnd_mat();
    rb = rnd_mat();
    tbl[0] = '{a: id,   b: f255, exp: pr('{255, 255, 255, 255, 255, 255, 255, 255, 255}), nm: "id_x_255"};
    tbl[1] = '{a: f255, b: f255, exp: pr('{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075}), nm: "255_x_255"};
    tbl[2] = '{a: id,   b: id,   exp: pr('{1, 0, 0, 0, 1, 0, 0, 0, 1}), nm: "id_x_id"};
    tbl[3] = '{a: ra,   b: rb,   exp: matmul(ra, rb), nm: "rand0"};
    tbl[4] = '{a: b_d,  b: a_d,  exp: matmul(b_d, a_d), nm: "swapped"};
    for (int v = 0; v < 5; v++) run_job(0, tbl[v].a, tbl[v].b, tbl[v].exp, tbl[v].nm);

    // Backpressure with late input changes.
    rr[0] = 1'b0;
    ra = rnd_mat();
    rb = rnd_mat();
    start_job(0, ra, rb);
    ma[0] = ~ra;
    wait_res(0, lat, arr_hi);
    chk("bp_latency", lat, 11);
    chk("bp_res", resv[0], matmul(ra, rb));
    saved = resv[0];
    for (int n = 0; n < 20; n++) begin
      if (n == 5) begin
        ma[0] = rnd_mat();
        inv[0] = 1'b1;
      end
      tick();
      chk("bp_valid_hold", rv[0], 1);
      chk("bp_res_stable", resv[0], saved);
      chk("bp_in_ready_low", inr[0], 0);
    end
    inv[0] = 1'b0;
    rr[0] = 1'b1;
    tick();
    chk("bp_release_valid", rv[0], 0);
    chk("bp_release_idle", inr[0], 1);

    // Reset during FEED beat 2.
    start_job(0, a_d, b_d);
    repeat (3) tick();
    chk("mid_beat2_a", lanes_a(0), {TDW'(1), TDW'(6), TDW'(4)});
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_lanes", {lanes_a(0), lanes_b(0)}, 0);
    chk("mid_rst_valid", rv[0], 0);
    chk("mid_rst_arr", arr_r[0], 0);
    chk("mid_rst_ready", inr[0], 1);
    chk("mid_rst_res", resv[0], 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    run_job(0, id, id, pr('{1, 0, 0, 0, 1, 0, 0, 0, 1}), "post_rst_id");

    // Short drain instance against its matching array model.
    run_job(1, a_d, b_d, pr('{177, 149, 100, 149, 133, 102, 19, 19, 16}), "d1_directed");
    for (int n = 0; n < 4; n++) begin
      ra = rnd_mat();
      rb = rnd_mat();
      run_job(1, ra, rb, matmul(ra, rb), $sformatf("d1_rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
